// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: payload plus valid bit, flush bubble insertion, stall hold and stall watchdog.
// Defining PIPE_STAGE_PERF_EN adds saturating stall_cycles / flush_cycles event counters.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [31:0]      BUBBLE_VAL = 32'h0000_0013,
  parameter int unsigned      MAX_STALL  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             valid_in,
  output logic [WIDTH-1:0] q,
  output logic             valid_out,
  output logic             stall_timeout
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_cycles
`endif
);

  localparam int unsigned      CNT_W    = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_STALL);
  localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_valid_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;

  // Flush beats stall beats load; reset is applied in the register process.
  always_comb begin
    w_q_nxt         = r_q;
    w_valid_nxt     = r_valid;
    w_stall_cnt_nxt = r_stall_cnt;
    if (flush) begin
      w_q_nxt         = BUBBLE_W;
      w_valid_nxt     = 1'b0;
      w_stall_cnt_nxt = '0;
    end else if (stall) begin
      if (r_stall_cnt != CNT_MAX) begin
        w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
      end
    end else begin
      w_q_nxt         = d;
      w_valid_nxt     = valid_in;
      w_stall_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= RESET_VAL;
      r_valid     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_q         <= w_q_nxt;
      r_valid     <= w_valid_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign q             = r_q;
  assign valid_out     = r_valid;
  assign stall_timeout = (r_stall_cnt == CNT_MAX);

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;
  logic [31:0] w_stall_cycles_nxt;
  logic [31:0] w_flush_cycles_nxt;

  // Event counters saturate rather than wrap so long runs never read as short ones.
  always_comb begin
    w_stall_cycles_nxt = r_stall_cycles;
    w_flush_cycles_nxt = r_flush_cycles;
    if (stall && !flush && (r_stall_cycles != PERF_MAX)) begin
      w_stall_cycles_nxt = r_stall_cycles + 32'd1;
    end
    if (flush && (r_flush_cycles != PERF_MAX)) begin
      w_flush_cycles_nxt = r_flush_cycles + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      r_stall_cycles <= w_stall_cycles_nxt;
      r_flush_cycles <= w_flush_cycles_nxt;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
`endif

endmodule
